// File: rtl/front_turbo_pkg.sv
// rtl/front_turbo_pkg.sv - shared types and constants for the front-turbo host sequencer
package front_turbo_pkg;

  localparam int         FT_RES_W   = 64;
  localparam int         FT_NSLOTS  = 4;
  localparam logic [7:0] FT_IDLE_VD = 8'hff;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_X,
    S_WR_Y,
    S_WR_FN,
    S_WAIT_SCAN,
    S_READ,
    S_OUT
  } ft_host_state_t;

  // Bit offset of result byte idx inside the 64-bit result word.
  function automatic logic [5:0] ft_byte_lsb(input logic [2:0] idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/front_turbo_host_seq_if.sv
// rtl/front_turbo_host_seq_if.sv - command, engine VD bus and result stream bundle
interface front_turbo_host_seq_if;
  import front_turbo_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [7:0]          cmd_x;
  logic [7:0]          cmd_y;
  logic [7:0]          cmd_fn;
  logic                scan_done;
  logic [7:0]          VD_out;
  logic                XSET;
  logic                YSET;
  logic                F2INS;
  logic [1:0]          VA;
  logic                REG0n;
  logic                REG1n;
  logic [7:0]          VD_in;
  logic                res_valid;
  logic                res_ready;
  logic [FT_RES_W-1:0] res_data;
  logic                res_timeout;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_fn, scan_done, VD_in, res_ready,
    output cmd_ready, VD_out, XSET, YSET, F2INS, VA, REG0n, REG1n,
           res_valid, res_data, res_timeout
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_fn, scan_done, VD_in, res_ready,
    input  cmd_ready, VD_out, XSET, YSET, F2INS, VA, REG0n, REG1n,
           res_valid, res_data, res_timeout
  );

endinterface

// File: rtl/front_turbo_rd_sched.sv
// rtl/front_turbo_rd_sched.sv - read slot scheduler: VA/REGxn generation and byte capture strobe
module front_turbo_rd_sched
  import front_turbo_pkg::*;
#(
  parameter int READ_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_i,
  output logic [1:0] va_o,
  output logic       reg0n_o,
  output logic       reg1n_o,
  output logic [2:0] idx_o,
  output logic       capture_o,
  output logic       last_o
);

  localparam int         CW       = $clog2(READ_WAIT + 1);
  localparam logic [2:0] LAST_IDX = 3'(2 * FT_NSLOTS - 1);

  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    va_q;
  logic          reg0n_q, reg1n_q;

  // Each read is one deselected cycle (cnt==0) followed by READ_WAIT selected cycles.
  assign capture_o = run_i && (cnt_q == CW'(READ_WAIT));
  assign last_o    = capture_o && (idx_q == LAST_IDX);
  assign idx_o     = idx_q;
  assign va_o      = va_q;
  assign reg0n_o   = reg0n_q;
  assign reg1n_o   = reg1n_q;

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (!run_i) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (cnt_q == CW'(READ_WAIT)) begin
      idx_d = idx_q + 3'd1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Select lines are registered from next-state so they line up with idx/cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      va_q    <= '0;
      reg0n_q <= 1'b1;
      reg1n_q <= 1'b1;
    end else begin
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      va_q    <= idx_d[1:0];
      reg0n_q <= ~((cnt_d != '0) & ~idx_d[2]);
      reg1n_q <= ~((cnt_d != '0) & idx_d[2]);
    end
  end

endmodule

// File: rtl/front_turbo_host_seq.sv
// rtl/front_turbo_host_seq.sv - programs the engine X/Y/FN registers, waits one scan, reads 8 result bytes
module front_turbo_host_seq
  import front_turbo_pkg::*;
#(
  parameter int READ_WAIT = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic                  clk,
  input  logic                  VIDEO_RST,
  front_turbo_host_seq_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT);

  ft_host_state_t      state_q, state_d;
  logic                ph_q, ph_d;
  logic [7:0]          x_q, x_d, y_q, y_d, fn_q, fn_d;
  logic [7:0]          vd_q, vd_d;
  logic                xset_q, xset_d, yset_q, yset_d, f2ins_q, f2ins_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic                res_valid_q, res_valid_d;
  logic [FT_RES_W-1:0] res_data_q, res_data_d;
  logic                res_to_q, res_to_d;

  logic [2:0] rd_idx;
  logic       rd_capture, rd_last;
  logic [1:0] rd_va;
  logic       rd_reg0n, rd_reg1n;

  front_turbo_rd_sched #(.READ_WAIT(READ_WAIT)) u_rd_sched (
    .clk       (clk),
    .rst       (VIDEO_RST),
    .run_i     (state_q == S_READ),
    .va_o      (rd_va),
    .reg0n_o   (rd_reg0n),
    .reg1n_o   (rd_reg1n),
    .idx_o     (rd_idx),
    .capture_o (rd_capture),
    .last_o    (rd_last)
  );

  always_comb begin
    state_d     = state_q;
    ph_d        = 1'b0;
    x_d         = x_q;
    y_d         = y_q;
    fn_d        = fn_q;
    vd_d        = FT_IDLE_VD;
    xset_d      = 1'b0;
    yset_d      = 1'b0;
    f2ins_d     = 1'b0;
    tcnt_d      = tcnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_to_d    = res_to_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          x_d     = bus.cmd_x;
          y_d     = bus.cmd_y;
          fn_d    = bus.cmd_fn;
          state_d = S_WR_X;
        end
      end
      // Phase 0 drives VD, phase 1 keeps it and fires the strobe.
      S_WR_X: begin
        vd_d = x_q;
        if (!ph_q) ph_d = 1'b1;
        else begin
          xset_d  = 1'b1;
          state_d = S_WR_Y;
        end
      end
      S_WR_Y: begin
        vd_d = y_q;
        if (!ph_q) ph_d = 1'b1;
        else begin
          yset_d  = 1'b1;
          state_d = S_WR_FN;
        end
      end
      S_WR_FN: begin
        vd_d = fn_q;
        if (!ph_q) ph_d = 1'b1;
        else begin
          f2ins_d = 1'b1;
          tcnt_d  = '0;
          state_d = S_WAIT_SCAN;
        end
      end
      // tcnt==0 is the cycle the FN strobe is visible; a scan_done there is stale.
      S_WAIT_SCAN: begin
        if (bus.scan_done && (tcnt_q != '0)) begin
          state_d = S_READ;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          res_data_d  = '1;
          res_to_d    = 1'b1;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      S_READ: begin
        if (rd_capture) res_data_d[ft_byte_lsb(rd_idx) +: 8] = bus.VD_in;
        if (rd_last) begin
          res_to_d    = 1'b0;
          res_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      state_q     <= S_IDLE;
      ph_q        <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      fn_q        <= '0;
      vd_q        <= FT_IDLE_VD;
      xset_q      <= 1'b0;
      yset_q      <= 1'b0;
      f2ins_q     <= 1'b0;
      tcnt_q      <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      x_q         <= x_d;
      y_q         <= y_d;
      fn_q        <= fn_d;
      vd_q        <= vd_d;
      xset_q      <= xset_d;
      yset_q      <= yset_d;
      f2ins_q     <= f2ins_d;
      tcnt_q      <= tcnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_to_q    <= res_to_d;
    end
  end

  assign bus.cmd_ready   = (state_q == S_IDLE) && !VIDEO_RST;
  assign bus.VD_out      = vd_q;
  assign bus.XSET        = xset_q;
  assign bus.YSET        = yset_q;
  assign bus.F2INS       = f2ins_q;
  assign bus.VA          = rd_va;
  assign bus.REG0n       = rd_reg0n;
  assign bus.REG1n       = rd_reg1n;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_data_q;
  assign bus.res_timeout = res_to_q;

endmodule

// File: tb/tb_front_turbo_host_seq.sv
// tb/tb_front_turbo_host_seq.sv - self-checking bench: vector table, reset abort, random commands vs model
module tb_front_turbo_host_seq;
  import front_turbo_pkg::*;

  localparam int RW = 2;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic VIDEO_RST;
  front_turbo_host_seq_if bus();

  front_turbo_host_seq #(.READ_WAIT(RW), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .VIDEO_RST (VIDEO_RST),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  logic [7:0] prev_vd = 8'hff;
  logic [31:0] eng0 = '0;
  logic [31:0] eng1 = '0;

  typedef struct {
    logic [7:0]  x, y, fn;
    logic [31:0] e0, e1;
    int          d;
    int          hold;
    bit          block;
    logic [63:0] exp_data;
    bit          exp_to;
  } vec_t;

  // Engine: selected bank/slot drives VD, otherwise bus idles high.
  always_comb begin
    bus.VD_in = 8'hff;
    if (!bus.REG0n)      bus.VD_in = eng0[{bus.VA, 3'b000} +: 8];
    else if (!bus.REG1n) bus.VD_in = eng1[{bus.VA, 3'b000} +: 8];
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("regn_exclusive", 64'(!bus.REG0n && !bus.REG1n), 64'd0);
      chk("strobe_onehot", 64'($countones({bus.XSET, bus.YSET, bus.F2INS}) > 1), 64'd0);
      if (bus.XSET || bus.YSET || bus.F2INS)
        chk("strobe_vd_setup", 64'(bus.VD_out), 64'(prev_vd));
    end
    prev_vd = bus.VD_out;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_result(input int d, input logic [31:0] e0, input logic [31:0] e1);
    logic [63:0] r;
    if (d < 1 || d > TO - 1) return '1;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) r[i*8 +: 8] = e0[(i % 4)*8 +: 8];
      else       r[i*8 +: 8] = e1[(i % 4)*8 +: 8];
    end
    return r;
  endfunction

  function automatic bit ref_timeout(input int d);
    return (d < 1 || d > TO - 1);
  endfunction

  task automatic send_cmd(input logic [7:0] x, input logic [7:0] y, input logic [7:0] fn, input bit noise);
    int n;
    logic [7:0] vals [3];
    logic [7:0] ev;
    logic [2:0] stb;
    n = 0;
    while (!bus.cmd_ready && n < 100) begin
      tick;
      n++;
    end
    chk("cmd_ready_wait", 64'(bus.cmd_ready), 64'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_x = x;
    bus.cmd_y = y;
    bus.cmd_fn = fn;
    tick;
    bus.cmd_valid = 1'b0;
    vals = '{x, y, fn};
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) tick;
      ev  = (k == 0) ? FT_IDLE_VD : vals[(k - 1) / 2];
      stb = (k > 0 && k % 2 == 0) ? (3'b100 >> (k / 2 - 1)) : 3'b000;
      chk($sformatf("write_seq[%0d]", k), 64'({bus.VD_out, bus.XSET, bus.YSET, bus.F2INS}), 64'({ev, stb}));
      bus.scan_done = (noise && k < 6) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  // Called in the cycle where F2INS is visible; d = cycles later that scan_done pulses.
  task automatic finish_txn(input int d, input int hold, input bit block, input logic [63:0] exp_data, input bit exp_to);
    int n;
    bit bad;
    if (d > 0) repeat (d) tick;
    bus.scan_done = 1'b1;
    tick;
    bus.scan_done = 1'b0;
    n = d + 1;
    while (!bus.res_valid && n < TO + 100) begin
      tick;
      n++;
    end
    chk("res_latency", 64'(n), 64'(exp_to ? TO : d + 1 + (1 + 8 * RW + 7)));
    chk("res_data", bus.res_data, exp_data);
    chk("res_timeout", 64'(bus.res_timeout), 64'(exp_to));
    bad = 1'b0;
    if (block) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_x = 8'($urandom);
      bus.cmd_y = 8'($urandom);
      bus.cmd_fn = 8'($urandom);
    end
    for (int h = 0; h < hold; h++) begin
      tick;
      if (!bus.res_valid || bus.res_data !== exp_data || bus.cmd_ready || bus.VD_out !== FT_IDLE_VD) bad = 1'b1;
    end
    if (hold > 0) chk("hold_stable", 64'(bad), 64'd0);
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    tick;
    bus.res_ready = 1'b0;
    chk("res_release", 64'({bus.res_valid, bus.cmd_ready}), 64'(2'b01));
  endtask

  initial begin
    vec_t vt [4];
    int n;
    int d;
    logic [7:0] rx, ry, rf;

    vt[0] = '{8'h12, 8'h34, 8'hc5, 32'h44332211, 32'h88776655, 3,      0,  1'b0, 64'h8877665544332211, 1'b0};
    vt[1] = '{8'ha5, 8'h5a, 8'h3f, 32'h0badf00d, 32'hcafe1234, 0,      2,  1'b0, 64'hffff_ffff_ffff_ffff, 1'b1};
    vt[2] = '{8'h00, 8'hff, 8'h80, 32'hdeadbeef, 32'h01234567, 1,      20, 1'b1, 64'h01234567deadbeef, 1'b0};
    vt[3] = '{8'h7e, 8'h81, 8'h40, 32'hf0e1d2c3, 32'h0f1e2d3c, TO - 1, 1,  1'b0, 64'h0f1e2d3cf0e1d2c3, 1'b0};

    VIDEO_RST = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_fn = '0;
    bus.scan_done = 1'b0;
    bus.res_ready = 1'b0;
    repeat (3) tick;
    chk("rst_outputs", 64'({bus.VD_out, bus.XSET, bus.YSET, bus.F2INS, bus.VA, bus.REG0n, bus.REG1n, bus.res_valid, bus.res_timeout}),
        64'({8'hff, 3'b000, 2'b00, 2'b11, 2'b00}));
    chk("rst_res_data", bus.res_data, 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    VIDEO_RST = 1'b0;
    #1;
    chk("cmd_ready_after_rst", 64'(bus.cmd_ready), 64'd1);
    mon_en = 1'b1;
    tick;

    for (int i = 0; i < 4; i++) begin
      eng0 = vt[i].e0;
      eng1 = vt[i].e1;
      send_cmd(vt[i].x, vt[i].y, vt[i].fn, 1'b0);
      finish_txn(vt[i].d, vt[i].hold, vt[i].block, vt[i].exp_data, vt[i].exp_to);
    end

    eng0 = 32'h13579bdf;
    eng1 = 32'h2468ace0;
    send_cmd(8'h01, 8'h02, 8'h03, 1'b0);
    tick;
    bus.scan_done = 1'b1;
    tick;
    bus.scan_done = 1'b0;
    n = 0;
    while (!(bus.VA == 2'd3 && !bus.REG0n) && n < 60) begin
      tick;
      n++;
    end
    chk("reach_read3", 64'(bus.VA == 2'd3 && !bus.REG0n), 64'd1);
    VIDEO_RST = 1'b1;
    tick;
    chk("rst_mid_read", 64'({bus.REG0n, bus.REG1n, bus.VD_out, bus.res_valid, bus.cmd_ready}),
        64'({1'b1, 1'b1, 8'hff, 1'b0, 1'b0}));
    VIDEO_RST = 1'b0;
    tick;
    chk("no_result_after_rst", 64'(bus.res_valid), 64'd0);
    send_cmd(8'h44, 8'h55, 8'h66, 1'b0);
    finish_txn(5, 0, 1'b0, ref_result(5, eng0, eng1), ref_timeout(5));

    for (int r = 0; r < 16; r++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      rf = 8'($urandom);
      eng0 = $urandom;
      eng1 = $urandom;
      d = $urandom_range(1, 40);
      send_cmd(rx, ry, rf, 1'b1);
      finish_txn(d, $urandom_range(0, 4), 1'b0, ref_result(d, eng0, eng1), ref_timeout(d));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
